lift_call_scheduler: RTL and testbench

//  Call scheduler for the 3-floor elevator FSM. Latches floor-button presses into
//  a pending set and picks one target at a time (SCAN: keep direction while

---
 rtl/lift_call_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_lift_call_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lift_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lift_call_scheduler
// Description : SCAN call scheduler for a 3-floor elevator. It latches button
//               edges into a pending set and dispatches one target at a time on
//               a one-hot call bus. Each request is retired once the car has
//               arrived and its door cycle has finished, or the serve timeout
//               has expired.
//               Optional travel watchdog: define LIFT_SCHED_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_call_scheduler #(
  parameter int SERVE_TIMEOUT = 8,
  parameter int WDOG_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] btn,
  input  logic [2:0] lift_state,
  output logic [2:0] call,
  output logic [2:0] pending,
  output logic [1:0] target,
  output logic       busy,
  output logic       dir_up,
  output logic       fault
);

  localparam int             c_SCNT_W     = $clog2(SERVE_TIMEOUT + 1);
  localparam logic [c_SCNT_W-1:0] c_SERVE_LAST = c_SCNT_W'(SERVE_TIMEOUT - 1);
  localparam logic [2:0]     c_LS_DOORS   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAVEL = 2'd1,
    S_SERVE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_btn_prev;
  logic [2:0]          r_pending, w_pending_nxt;
  logic [1:0]          r_last_floor, w_last_floor_nxt;
  logic [1:0]          r_target, w_target_nxt;
  logic [2:0]          r_call, w_call_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_dir_up, w_dir_up_nxt;
  logic [c_SCNT_W-1:0] r_serve_cnt, w_serve_cnt_nxt;
  logic                r_door_seen, w_door_seen_nxt;
  logic [2:0]          w_btn_rise;
  logic [2:0]          w_clr;

  // SCAN selection results
  logic                w_above_ok, w_below_ok;
  logic [1:0]          w_above, w_below;
  logic [1:0]          w_sel_floor;
  logic                w_sel_dir;

`ifdef LIFT_SCHED_WDOG_EN
  localparam int                  c_WCNT_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_WCNT_W-1:0] c_WDOG_LAST = c_WCNT_W'(WDOG_CYCLES - 1);
  logic [c_WCNT_W-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
  logic                r_fault, w_fault_nxt;
`endif

  function automatic logic [2:0] onehot3(input logic [1:0] f);
    onehot3 = 3'b001 << f;
  endfunction

  // Nearest pending floor above and below the last known floor
  always_comb begin
    w_above_ok  = 1'b0;
    w_above     = r_last_floor;
    w_below_ok  = 1'b0;
    w_below     = r_last_floor;
    w_sel_floor = r_last_floor;
    w_sel_dir   = r_dir_up;
    case (r_last_floor)
      2'd0: begin
        if (r_pending[1]) begin
          w_above_ok = 1'b1; w_above = 2'd1;
        end else if (r_pending[2]) begin
          w_above_ok = 1'b1; w_above = 2'd2;
        end
      end
      2'd1: begin
        if (r_pending[2]) begin
          w_above_ok = 1'b1; w_above = 2'd2;
        end
        if (r_pending[0]) begin
          w_below_ok = 1'b1; w_below = 2'd0;
        end
      end
      default: begin
        if (r_pending[1]) begin
          w_below_ok = 1'b1; w_below = 2'd1;
        end else if (r_pending[0]) begin
          w_below_ok = 1'b1; w_below = 2'd0;
        end
      end
    endcase
    // Keep direction while requests lie ahead, otherwise reverse.
    // With nothing ahead or behind, the only request is the last floor itself
    // (car has left it), so it is dispatched in place.
    if (r_dir_up) begin
      if (w_above_ok) begin
        w_sel_floor = w_above;
      end else if (w_below_ok) begin
        w_sel_floor = w_below; w_sel_dir = 1'b0;
      end
    end else begin
      if (w_below_ok) begin
        w_sel_floor = w_below;
      end else if (w_above_ok) begin
        w_sel_floor = w_above; w_sel_dir = 1'b1;
      end
    end
  end

  // Next-state and output decode for the IDLE/TRAVEL/SERVE controller
  always_comb begin
    w_btn_rise       = btn & ~r_btn_prev;
    w_clr            = 3'b000;
    w_state_nxt      = r_state;
    w_target_nxt     = r_target;
    w_call_nxt       = r_call;
    w_busy_nxt       = r_busy;
    w_dir_up_nxt     = r_dir_up;
    w_serve_cnt_nxt  = r_serve_cnt;
    w_door_seen_nxt  = r_door_seen;
    w_last_floor_nxt = (lift_state <= 3'd2) ? lift_state[1:0] : r_last_floor;
`ifdef LIFT_SCHED_WDOG_EN
    w_wdog_cnt_nxt   = r_wdog_cnt;
    w_fault_nxt      = r_fault;
`endif
    case (r_state)
      S_IDLE: begin
        if (|(r_pending & onehot3(r_last_floor)) &&
            (lift_state == {1'b0, r_last_floor})) begin
          // Car is already standing at the requested floor
          w_clr = onehot3(r_last_floor);
        end else if (r_pending != 3'b000) begin
          w_target_nxt   = w_sel_floor;
          w_dir_up_nxt   = w_sel_dir;
          w_call_nxt     = onehot3(w_sel_floor);
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_TRAVEL;
`ifdef LIFT_SCHED_WDOG_EN
          w_wdog_cnt_nxt = '0;
`endif
        end
      end
      S_TRAVEL: begin
        if ((lift_state == {1'b0, r_target}) || (lift_state == c_LS_DOORS)) begin
          w_call_nxt      = 3'b000;
          w_state_nxt     = S_SERVE;
          w_serve_cnt_nxt = '0;
          w_door_seen_nxt = 1'b0;
`ifdef LIFT_SCHED_WDOG_EN
        end else if (r_wdog_cnt == c_WDOG_LAST) begin
          // Give up on this trip; pending bit stays set so it is retried
          w_fault_nxt = 1'b1;
          w_call_nxt  = 3'b000;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_wdog_cnt_nxt = r_wdog_cnt + 1'b1;
`endif
        end
      end
      S_SERVE: begin
        // Codes 6/7 are not a valid "doors closed" indication
        if ((r_door_seen && (lift_state < c_LS_DOORS)) ||
            (r_serve_cnt == c_SERVE_LAST)) begin
          w_clr       = onehot3(r_target);
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_serve_cnt_nxt = r_serve_cnt + 1'b1;
          if (lift_state == c_LS_DOORS) w_door_seen_nxt = 1'b1;
        end
      end
      default: begin
        w_call_nxt  = 3'b000;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    // Clear beats a same-cycle new press: that request is treated as served
    w_pending_nxt = (r_pending | w_btn_rise) & ~w_clr;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_btn_prev   <= 3'b000;
      r_pending    <= 3'b000;
      r_last_floor <= 2'd0;
      r_target     <= 2'd0;
      r_call       <= 3'b000;
      r_busy       <= 1'b0;
      r_dir_up     <= 1'b1;
      r_serve_cnt  <= '0;
      r_door_seen  <= 1'b0;
`ifdef LIFT_SCHED_WDOG_EN
      r_wdog_cnt   <= '0;
      r_fault      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_btn_prev   <= btn;
      r_pending    <= w_pending_nxt;
      r_last_floor <= w_last_floor_nxt;
      r_target     <= w_target_nxt;
      r_call       <= w_call_nxt;
      r_busy       <= w_busy_nxt;
      r_dir_up     <= w_dir_up_nxt;
      r_serve_cnt  <= w_serve_cnt_nxt;
      r_door_seen  <= w_door_seen_nxt;
`ifdef LIFT_SCHED_WDOG_EN
      r_wdog_cnt   <= w_wdog_cnt_nxt;
      r_fault      <= w_fault_nxt;
`endif
    end
  end

  assign call    = r_call;
  assign pending = r_pending;
  assign target  = r_target;
  assign busy    = r_busy;
  assign dir_up  = r_dir_up;
`ifdef LIFT_SCHED_WDOG_EN
  assign fault   = r_fault;
`else
  assign fault   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lift_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_call_scheduler
// Description : Directed self-checking bench for lift_call_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_call_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] btn;
  logic [2:0] lift_state;
  logic [2:0] call;
  logic [2:0] pending;
  logic [1:0] target;
  logic       busy;
  logic       dir_up;
  logic       fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lift_call_scheduler #(
    .SERVE_TIMEOUT(8),
    .WDOG_CYCLES  (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn       (btn),
    .lift_state(lift_state),
    .call      (call),
    .pending   (pending),
    .target    (target),
    .busy      (busy),
    .dir_up    (dir_up),
    .fault     (fault)
  );

  // Advance one clock; sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; btn = 3'b000; lift_state = 3'd0;
    repeat (2) tick();
    check("rst_call",    call,    3'b000);
    check("rst_pending", pending, 3'b000);
    check("rst_target",  target,  2'd0);
    check("rst_busy",    busy,    1'b0);
    check("rst_dir_up",  dir_up,  1'b1);
    check("rst_fault",   fault,   1'b0);
    reset_n = 1'b1;
    tick();

    // Floor 0, request floor 2, full door cycle
    btn = 3'b100; tick();
    check("t2_pending_set", pending, 3'b100);
    check("t2_call_not_yet", call, 3'b000);
    btn = 3'b000; tick();
    check("t2_call", call, 3'b100);
    check("t2_busy", busy, 1'b1);
    check("t2_target", target, 2'd2);
    check("t2_dir", dir_up, 1'b1);
    lift_state = 3'd3; tick(); tick();
    check("t2_call_hold", call, 3'b100);
    check("t2_pending_hold", pending, 3'b100);
    lift_state = 3'd2; tick();
    check("t2_arrive_call", call, 3'b000);
    check("t2_arrive_busy", busy, 1'b1);
    check("t2_arrive_pending", pending, 3'b100);
    lift_state = 3'd5; tick();
    check("t2_doors_pending", pending, 3'b100);
    lift_state = 3'd2; tick();
    check("t2_done_pending", pending, 3'b000);
    check("t2_done_busy", busy, 1'b0);

    // Floor 2 -> floor 1, serve timeout, btn edge on exit dropped
    btn = 3'b010; tick();
    check("t5_pending", pending, 3'b010);
    btn = 3'b000; tick();
    check("t5_call", call, 3'b010);
    check("t5_target", target, 2'd1);
    check("t5_dir_down", dir_up, 1'b0);
    lift_state = 3'd4; tick();
    lift_state = 3'd1; tick();
    check("t5_serve_call", call, 3'b000);
    repeat (7) tick();
    check("t5_still_busy", busy, 1'b1);
    check("t5_still_pending", pending, 3'b010);
    btn = 3'b010; tick();
    check("t5_exit_pending", pending, 3'b000);
    check("t5_exit_busy", busy, 1'b0);
    tick();
    check("t5_level_no_rereq", pending, 3'b000);
    btn = 3'b000; tick();

    // Idle at floor 1, press floor 1: cleared without dispatch
    btn = 3'b010; tick();
    check("t4_pending_set", pending, 3'b010);
    check("t4_call0", call, 3'b000);
    btn = 3'b000; tick();
    check("t4_pending_clr", pending, 3'b000);
    check("t4_call", call, 3'b000);
    check("t4_busy", busy, 1'b0);

    // Reset asserted mid-TRAVEL (dir_up was 0, reversal sets it to 1)
    btn = 3'b100; tick();
    btn = 3'b000; tick();
    check("t1_call", call, 3'b100);
    check("t1_dir_rev", dir_up, 1'b1);
    lift_state = 3'd3; tick();
    reset_n = 1'b0; #1;
    check("t1_async_call", call, 3'b000);
    check("t1_async_pending", pending, 3'b000);
    check("t1_async_busy", busy, 1'b0);
    check("t1_async_target", target, 2'd0);
    tick();
    check("t1_edge_call", call, 3'b000);
    check("t1_edge_dir", dir_up, 1'b1);
    lift_state = 3'd1; reset_n = 1'b1; tick();

    // Floor 1, dir up, requests for 0 and 2 together
    btn = 3'b101; tick();
    check("t3_pending", pending, 3'b101);
    btn = 3'b000; tick();
    check("t3_call_first", call, 3'b100);
    check("t3_target_first", target, 2'd2);
    check("t3_dir_first", dir_up, 1'b1);
    lift_state = 3'd3; tick();
    check("t3_call_hold", call, 3'b100);
    lift_state = 3'd2; tick();
    check("t3_arrive_call", call, 3'b000);
    lift_state = 3'd5; tick();
    lift_state = 3'd2; tick();
    check("t3_first_done", pending, 3'b001);
    check("t3_first_busy", busy, 1'b0);
    tick();
    check("t3_call_second", call, 3'b001);
    check("t3_target_second", target, 2'd0);
    check("t3_dir_second", dir_up, 1'b0);
    lift_state = 3'd4; tick();
    lift_state = 3'd0; tick();
    check("t3_arrive2_call", call, 3'b000);
    lift_state = 3'd5; tick();
    lift_state = 3'd0; tick();
    check("t3_done_pending", pending, 3'b000);
    check("t3_done_busy", busy, 1'b0);

    // Travel stall: watchdog behaviour depends on build option
    btn = 3'b010; tick();
    btn = 3'b000; tick();
    check("t6_call", call, 3'b010);
    check("t6_dir", dir_up, 1'b1);
    lift_state = 3'd3;
`ifdef LIFT_SCHED_WDOG_EN
    repeat (31) tick();
    check("t6_pre_fault", fault, 1'b0);
    check("t6_pre_call", call, 3'b010);
    tick();
    check("t6_fault", fault, 1'b1);
    check("t6_fault_call", call, 3'b000);
    check("t6_fault_busy", busy, 1'b0);
    check("t6_fault_pending", pending, 3'b010);
    tick();
    check("t6_redispatch_call", call, 3'b010);
    check("t6_redispatch_busy", busy, 1'b1);
`else
    repeat (40) tick();
    check("t6_call_held", call, 3'b010);
    check("t6_no_fault", fault, 1'b0);
    check("t6_busy_held", busy, 1'b1);
`endif
    lift_state = 3'd1; tick();
    check("t6_arrive_call", call, 3'b000);
    lift_state = 3'd5; tick();
    lift_state = 3'd1; tick();
    check("t6_done_pending", pending, 3'b000);
    check("t6_done_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
